// File: rtl/axi4_stream_pkg.sv
// Shared AXI4-Stream definitions.
// - Default field widths used by the stream interface and the FIFO.
// - axis_beat_width(): width of one packed beat
//   (tdata, tstrb, tkeep, tlast, tid, tdest, tuser). The FIFO uses it to size
//   its storage word.
package axi4_stream_pkg;

  localparam int AXIS_ID_WIDTH_DEF   = 8;
  localparam int AXIS_DATA_WIDTH_DEF = 32;
  localparam int AXIS_DEST_WIDTH_DEF = 4;
  localparam int AXIS_USER_WIDTH_DEF = 32;

  // Width of a packed beat. tstrb and tkeep each carry one bit per data byte,
  // and tlast is a single bit.
  function automatic int axis_beat_width(int id, int data, int dest, int user);
    return data + 2 * (data / 8) + 1 + id + dest + user;
  endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle carrying one beat per handshake.
// - master modport: drives the payload and tvalid, and receives tready.
// - slave modport: receives the payload and tvalid, and drives tready.
interface axi4_stream_if #(
  parameter int ID_WIDTH   = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEST_WIDTH = 4,
  parameter int USER_WIDTH = 32
);
  logic                    tvalid;
  logic                    tready;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;
  logic [ID_WIDTH-1:0]     tid;
  logic [DEST_WIDTH-1:0]   tdest;
  logic [USER_WIDTH-1:0]   tuser;

  modport master (
    output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    output tready
  );
endinterface

// File: rtl/axi4_stream_fifo_mem.sv
// Beat storage for axi4_stream_fifo: DEPTH words of WIDTH bits.
// - Writes are synchronous and reads are asynchronous, which lets synthesis map
//   the array to distributed RAM.
// - The array has no reset. Its contents are meaningful only where the FIFO
//   pointers say so.
// Ports:
//   clk_i   - clock
//   we_i    - write enable
//   waddr_i - write address
//   wdata_i - write word
//   raddr_i - read address
//   rdata_o - read word (combinational)
module axi4_stream_fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Synchronous write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_r[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_r[raddr_i];

endmodule

// File: rtl/axi4_stream_fifo.sv
// First-word-fall-through AXI4-Stream FIFO on a single clock.
// Ports:
//   clk_i     - clock; all state changes on the rising edge
//   rst_n_i   - asynchronous active-low reset
//   s_axis    - input stream (slave); beats are written here
//   m_axis    - output stream (master); beats are read here
//   level_o   - number of beats stored, 0..DEPTH
//   pkt_cnt_o - number of stored beats that have tlast=1
//   full_o    - level_o == DEPTH
//   empty_o   - level_o == 0
module axi4_stream_fifo
  import axi4_stream_pkg::*;
#(
  parameter int ID_WIDTH   = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEST_WIDTH = 4,
  parameter int USER_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  axi4_stream_if.slave             s_axis,
  axi4_stream_if.master            m_axis,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [$clog2(DEPTH):0]   pkt_cnt_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW     = $clog2(DEPTH);
  localparam int PW     = AW + 1;
  localparam int BEAT_W = axis_beat_width(ID_WIDTH, DATA_WIDTH, DEST_WIDTH, USER_WIDTH);

  // The MSB of each pointer is a wrap bit. It tells full from empty when the
  // low address bits are equal.
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [PW-1:0]     pkt_cnt_r;
  logic [PW-1:0]     pkt_cnt_nxt_s;
  logic              rdy_en_r;
  logic              full_s;
  logic              empty_s;
  logic              push_s;
  logic              pop_s;
  logic [BEAT_W-1:0] wr_word_s;
  logic [BEAT_W-1:0] rd_word_s;

  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);

  // tready depends only on local state. This keeps consumer back-pressure from
  // forming a combinational path to the producer.
  assign s_axis.tready = !full_s && rdy_en_r;
  assign m_axis.tvalid = !empty_s;

  assign push_s = s_axis.tvalid && s_axis.tready;
  assign pop_s  = m_axis.tvalid && m_axis.tready;

  // Beat pack and unpack. The field order is the same in both directions.
  assign wr_word_s = {s_axis.tdata, s_axis.tstrb, s_axis.tkeep, s_axis.tlast,
                      s_axis.tid, s_axis.tdest, s_axis.tuser};
  assign {m_axis.tdata, m_axis.tstrb, m_axis.tkeep, m_axis.tlast,
          m_axis.tid, m_axis.tdest, m_axis.tuser} = rd_word_s;

  axi4_stream_fifo_mem #(
    .WIDTH (BEAT_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (push_s),
    .waddr_i (wr_ptr_r[AW-1:0]),
    .wdata_i (wr_word_s),
    .raddr_i (rd_ptr_r[AW-1:0]),
    .rdata_o (rd_word_s)
  );

  // Enables tready from the first edge after reset is released.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rdy_en_r <= 1'b0;
    end else begin
      rdy_en_r <= 1'b1;
    end
  end

  // Write and read pointers. Going past DEPTH-1 wraps by natural overflow.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
    end
  end

  // Next value of the packet counter. A tlast beat entering and another
  // leaving in the same cycle cancel out.
  always_comb begin
    pkt_cnt_nxt_s = pkt_cnt_r;
    case ({push_s && s_axis.tlast, pop_s && m_axis.tlast})
      2'b10:   pkt_cnt_nxt_s = pkt_cnt_r + PW'(1);
      2'b01:   pkt_cnt_nxt_s = pkt_cnt_r - PW'(1);
      default: pkt_cnt_nxt_s = pkt_cnt_r;
    endcase
  end

  // Packet counter register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pkt_cnt_r <= '0;
    end else begin
      pkt_cnt_r <= pkt_cnt_nxt_s;
    end
  end

  assign level_o   = wr_ptr_r - rd_ptr_r;
  assign pkt_cnt_o = pkt_cnt_r;
  assign full_o    = full_s;
  assign empty_o   = empty_s;

endmodule

// File: tb/tb_axi4_stream_fifo.sv
// Directed self-checking bench for axi4_stream_fifo with DEPTH=4.
module tb_axi4_stream_fifo;
  localparam int IDW = 8;
  localparam int DW  = 32;
  localparam int DSW = 4;
  localparam int UW  = 32;
  localparam int DEP = 4;

  logic       clk;
  logic       rst_n;
  logic [2:0] level;
  logic [2:0] pkt_cnt;
  logic       full;
  logic       empty;

  int n_cmp = 0;
  int n_err = 0;

  axi4_stream_if #(.ID_WIDTH(IDW), .DATA_WIDTH(DW), .DEST_WIDTH(DSW), .USER_WIDTH(UW)) s_if ();
  axi4_stream_if #(.ID_WIDTH(IDW), .DATA_WIDTH(DW), .DEST_WIDTH(DSW), .USER_WIDTH(UW)) m_if ();

  axi4_stream_fifo #(
    .ID_WIDTH(IDW), .DATA_WIDTH(DW), .DEST_WIDTH(DSW), .USER_WIDTH(UW), .DEPTH(DEP)
  ) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .s_axis    (s_if),
    .m_axis    (m_if),
    .level_o   (level),
    .pkt_cnt_o (pkt_cnt),
    .full_o    (full),
    .empty_o   (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [31:0] data, input logic last);
    s_if.tvalid = 1'b1;
    s_if.tdata  = data;
    s_if.tlast  = last;
    step();
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  logic acc;
  int   in_idx;
  int   out_idx;
  int   cyc;
  logic [31:0] exp_out [5];

  initial begin
    rst_n       = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = 32'h0;
    s_if.tstrb  = 4'hF;
    s_if.tkeep  = 4'hF;
    s_if.tlast  = 1'b0;
    s_if.tid    = 8'h0;
    s_if.tdest  = 4'h0;
    s_if.tuser  = 32'h0;
    m_if.tready = 1'b0;

    // Reset, then idle
    #23;
    check_value("rst_tready", 64'(s_if.tready), 64'd0);
    check_value("rst_tvalid", 64'(m_if.tvalid), 64'd0);
    check_value("rst_level", 64'(level), 64'd0);
    check_value("rst_pkt", 64'(pkt_cnt), 64'd0);
    check_value("rst_empty", 64'(empty), 64'd1);
    check_value("rst_full", 64'(full), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_value("tready_before_edge", 64'(s_if.tready), 64'd0);
    step();
    check_value("tready_after_edge", 64'(s_if.tready), 64'd1);

    // Fill to DEPTH with the consumer stalled
    for (int i = 0; i < 4; i++) push_beat(32'hA0 + 32'(i), 1'b0);
    check_value("fill_level", 64'(level), 64'd4);
    check_value("fill_full", 64'(full), 64'd1);
    check_value("fill_tready", 64'(s_if.tready), 64'd0);
    s_if.tvalid = 1'b1;
    s_if.tdata  = 32'hA4;
    step();
    check_value("full_hold_level", 64'(level), 64'd4);
    exp_out[0] = 32'hA0; exp_out[1] = 32'hA1; exp_out[2] = 32'hA2;
    exp_out[3] = 32'hA3; exp_out[4] = 32'hA4;
    m_if.tready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check_value("drain_valid", 64'(m_if.tvalid), 64'd1);
      check_value("drain_data", 64'(m_if.tdata), 64'(exp_out[k]));
      acc = s_if.tvalid & s_if.tready;
      step();
      if (acc) s_if.tvalid = 1'b0;
    end
    check_value("drain_empty", 64'(empty), 64'd1);
    check_value("drain_level", 64'(level), 64'd0);

    // Streaming with both sides always ready
    s_if.tvalid = 1'b1;
    s_if.tdata  = 32'd0;
    in_idx = 0; out_idx = 0; cyc = 0;
    while (out_idx < 100 && cyc < 300) begin
      acc = s_if.tvalid & s_if.tready;
      step();
      cyc++;
      if (acc) in_idx++;
      if (in_idx < 100) begin
        s_if.tvalid = 1'b1;
        s_if.tdata  = 32'(in_idx);
      end else begin
        s_if.tvalid = 1'b0;
      end
      check_value("stream_level_le1", 64'(level <= 3'd1), 64'd1);
      if (m_if.tvalid) begin
        check_value("stream_data", 64'(m_if.tdata), 64'(out_idx));
        out_idx++;
      end
    end
    check_value("stream_count", 64'(out_idx), 64'd100);
    check_value("stream_cycles", 64'(cyc), 64'd100);
    step();
    check_value("stream_empty", 64'(empty), 64'd1);

    // Back-pressure stability
    m_if.tready = 1'b0;
    s_if.tid = 8'd3; s_if.tdest = 4'd2; s_if.tuser = 32'h1234; s_if.tkeep = 4'hF;
    push_beat(32'h55, 1'b1);
    s_if.tid = 8'd0; s_if.tdest = 4'd0; s_if.tuser = 32'h0;
    push_beat(32'h66, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check_value("bp_valid", 64'(m_if.tvalid), 64'd1);
      check_value("bp_data", 64'(m_if.tdata), 64'h55);
      check_value("bp_tid", 64'(m_if.tid), 64'd3);
      check_value("bp_tdest", 64'(m_if.tdest), 64'd2);
      check_value("bp_tuser", 64'(m_if.tuser), 64'h1234);
      check_value("bp_tkeep", 64'(m_if.tkeep), 64'hF);
      check_value("bp_tlast", 64'(m_if.tlast), 64'd1);
      step();
    end
    check_value("bp_pkt_before", 64'(pkt_cnt), 64'd1);
    m_if.tready = 1'b1;
    step();
    m_if.tready = 1'b0;
    check_value("bp_one_pop_level", 64'(level), 64'd1);
    check_value("bp_next_data", 64'(m_if.tdata), 64'h66);
    check_value("bp_pkt_after", 64'(pkt_cnt), 64'd0);
    m_if.tready = 1'b1;
    step();
    m_if.tready = 1'b0;
    check_value("bp_empty", 64'(empty), 64'd1);

    // Packet count
    push_beat(32'h10, 1'b0);
    push_beat(32'h11, 1'b0);
    push_beat(32'h12, 1'b1);
    push_beat(32'h20, 1'b1);
    check_value("pkt_two", 64'(pkt_cnt), 64'd2);
    m_if.tready = 1'b1;
    step(); step(); step();
    m_if.tready = 1'b0;
    check_value("pkt_after_pop3", 64'(pkt_cnt), 64'd1);
    check_value("pkt_level1", 64'(level), 64'd1);
    m_if.tready = 1'b1;
    push_beat(32'h99, 1'b1);
    m_if.tready = 1'b0;
    check_value("pkt_simul", 64'(pkt_cnt), 64'd1);
    check_value("pkt_simul_level", 64'(level), 64'd1);
    check_value("pkt_simul_data", 64'(m_if.tdata), 64'h99);
    m_if.tready = 1'b1;
    step();
    m_if.tready = 1'b0;
    check_value("pkt_zero", 64'(pkt_cnt), 64'd0);

    // Reset mid-packet
    push_beat(32'h31, 1'b0);
    push_beat(32'h32, 1'b0);
    push_beat(32'h33, 1'b0);
    check_value("mid_level3", 64'(level), 64'd3);
    rst_n = 1'b0;
    #1;
    check_value("mid_rst_valid", 64'(m_if.tvalid), 64'd0);
    check_value("mid_rst_level", 64'(level), 64'd0);
    check_value("mid_rst_empty", 64'(empty), 64'd1);
    check_value("mid_rst_tready", 64'(s_if.tready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_value("mid_rel_tready", 64'(s_if.tready), 64'd1);
    push_beat(32'h77, 1'b0);
    check_value("mid_new_valid", 64'(m_if.tvalid), 64'd1);
    check_value("mid_new_data", 64'(m_if.tdata), 64'h77);
    check_value("mid_new_level", 64'(level), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
